// File: rtl/prog_run_ctrl_pkg.sv
// Shared definitions for the program load/run controller: FSM encoding,
// the default halt instruction and counter sizing helpers.
package prog_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_FIN  = 3'd4
  } run_state_e;

  // RV32 ecall, used as the end-of-program marker.
  localparam logic [31:0] HALT_INSN_ECALL = 32'h0000_0073;

  localparam int unsigned CNT_W = 32;

  // Terminal count for an N-cycle interval starting at zero; N below 1 is treated as 1.
  function automatic logic [CNT_W-1:0] term_value(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/prog_run_ctrl_run_cycle_counter.sv
// Loadable, saturating up-counter with a terminal-count compare, shared by
// the reset-hold interval and the run-cycle budget.
module run_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  // Load has priority over counting; counting stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == i_term);

endmodule

// File: rtl/prog_run_ctrl.sv
// Program load/run controller: streams a program into instruction memory,
// holds the core in reset for a fixed interval, then lets it run until it
// fetches the halt instruction or exhausts its cycle budget.
module prog_run_ctrl
  import prog_run_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 10,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        RST_CYCLES = 2,
  parameter int unsigned        MAX_CYCLES = 75,
  parameter logic [DATA_W-1:0]  HALT_INSN  = DATA_W'(HALT_INSN_ECALL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  input  logic [DATA_W-1:0] core_insn,
  input  logic              core_insn_vld,
  output logic [31:0]       cycle_cnt,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] HOLD_TERM = term_value(RST_CYCLES);
  localparam logic [CNT_W-1:0] RUN_TERM  = term_value(MAX_CYCLES);

  run_state_e        r_state;
  run_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_halted;
  logic              r_timeout;
  logic              r_overflow;

  logic              w_clear;
  logic              w_cnt_load;
  logic              w_cnt_en;
  logic [CNT_W-1:0]  w_term;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_term;
  logic              w_addr_max;
  logic              w_halt_hit;
  logic              w_set_halt;
  logic              w_set_timeout;
  logic              w_set_ovf;

  assign w_addr_max = (r_addr == '1);
  assign w_halt_hit = core_insn_vld && (core_insn == HALT_INSN);

  // Compare target depends only on state, kept outside the FSM block so the
  // terminal flag never feeds back into its own select.
  assign w_term = (r_state == ST_RUN) ? RUN_TERM : HOLD_TERM;

  run_cycle_counter #(
    .W (CNT_W)
  ) u_cycle_counter (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_cnt_load),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .i_term     (w_term),
    .o_cnt      (w_cnt),
    .o_term     (w_cnt_term)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, load-port handshake, memory write and counter control.
  always_comb begin
    w_next        = r_state;
    ld_ready      = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    w_clear       = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_en      = 1'b0;
    w_set_halt    = 1'b0;
    w_set_timeout = 1'b0;
    w_set_ovf     = 1'b0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          w_next     = ST_LOAD;
          w_clear    = 1'b1;
          w_cnt_load = 1'b1;
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = r_addr;
          mem_wdata = ld_data;
          if (ld_last || w_addr_max) begin
            w_next     = ST_HOLD;
            w_cnt_load = 1'b1;
            w_set_ovf  = !ld_last;
          end
        end
      end
      ST_HOLD: begin
        if (w_cnt_term) begin
          w_next     = ST_RUN;
          w_cnt_load = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_halt_hit) begin
          w_next     = ST_FIN;
          w_set_halt = 1'b1;
        end else if (w_cnt_term) begin
          w_next        = ST_FIN;
          w_set_timeout = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Write address: cleared on a new sequence, never wraps past the top word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (w_clear) begin
      r_addr <= '0;
    end else if (mem_we && !w_addr_max) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Sticky status flags, cleared when a new sequence starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_set_halt)    r_halted   <= 1'b1;
      if (w_set_timeout) r_timeout  <= 1'b1;
      if (w_set_ovf)     r_overflow <= 1'b1;
    end
  end

  assign core_rst = (r_state != ST_RUN);
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_HOLD) || (r_state == ST_RUN);
  assign done     = (r_state == ST_FIN);
  assign halted   = r_halted;
  assign timeout  = r_timeout;
  assign overflow = r_overflow;
  // The shared counter is counting reset-hold cycles in HOLD; no run cycles have elapsed yet.
  assign cycle_cnt = (r_state == ST_HOLD) ? '0 : w_cnt;

endmodule

// File: doc/prog_run_ctrl.md
PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory address width (depth 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter RST_CYCLES, default 2, cycles the core reset is held after load (minimum 1).
REQ-004 SHALL have parameter MAX_CYCLES, default 75, run-cycle budget before timeout (minimum 1).
REQ-005 SHALL have parameter HALT_INSN, default 32'h00000073 (ecall), instruction word that ends a run.
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a load/run sequence.
REQ-009 SHALL have port ld_valid  in  1  load word valid.
REQ-010 SHALL have port ld_ready  out  1  load word accepted when high together with ld_valid.
REQ-011 SHALL have port ld_data  in  DATA_W  load word.
REQ-012 SHALL have port ld_last  in  1  marks the final load word.
REQ-013 SHALL have port mem_we  out  1  instruction-memory write enable.
REQ-014 SHALL have port mem_addr  out  ADDR_W  instruction-memory write address.
REQ-015 SHALL have port mem_wdata  out  DATA_W  instruction-memory write data.
REQ-016 SHALL have port core_rst  out  1  active-high reset to the pipelined core.
REQ-017 SHALL have port core_insn  in  DATA_W  instruction currently in the core's fetch stage.
REQ-018 SHALL have port core_insn_vld  in  1  core_insn is valid this cycle.
REQ-019 SHALL have port cycle_cnt  out  32  run cycles elapsed since core_rst deasserted.
REQ-020 SHALL have ports busy, done, halted, timeout, overflow  out  1 each  status flags.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, HOLD, RUN, FIN.
REQ-022 IDLE: start -> LOAD, clearing address, cycle_cnt and all status flags; start in any state other than IDLE or FIN SHALL be ignored.
REQ-023 LOAD: ld_ready=1; each ld_valid&&ld_ready SHALL drive mem_we=1, mem_addr=current address, mem_wdata=ld_data combinationally in that cycle, then increment address.
REQ-024 LOAD: accepted word with ld_last=1 -> HOLD.
REQ-025 LOAD: accepted word at address 2**ADDR_W-1 with ld_last=0 SHALL be written, set overflow=1, -> HOLD; address SHALL never wrap.
REQ-026 HOLD: count RST_CYCLES cycles, then -> RUN.
REQ-027 core_rst SHALL be 1 in IDLE, LOAD, HOLD, FIN and 0 only in RUN.
REQ-028 RUN: cycle_cnt SHALL increment by 1 every cycle, saturating at 2**32-1.
REQ-029 RUN: core_insn_vld && core_insn==HALT_INSN -> FIN with halted=1.
REQ-030 RUN: cycle_cnt==MAX_CYCLES-1 with no halt that cycle -> FIN with timeout=1.
REQ-031 Halt and budget exhaustion in the same cycle: halted=1, timeout=0.
REQ-032 FIN: done=1, flags and cycle_cnt held; start -> LOAD with REQ-022 clearing.
REQ-033 busy SHALL be 1 in LOAD, HOLD, RUN; 0 in IDLE, FIN.
REQ-034 ld_ready and mem_we SHALL be 0 outside LOAD.

Reset
REQ-035 rst low SHALL immediately force IDLE, core_rst=1, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cycle_cnt=0, busy=done=halted=timeout=overflow=0, including mid-load or mid-run.
REQ-036 After rst rises, the block SHALL remain in IDLE until start.

Structure
REQ-037 FSM state encoding and default HALT_INSN constant SHALL live in the shared riscv package.
REQ-038 The HOLD/RUN cycle counter SHALL be one sub-module, run_cycle_counter (load, enable, saturating, terminal-compare output).

Verification
REQ-039 start, 4 words (last on 4th), no stalls -> mem writes at addr 0..3 in 4 consecutive cycles, core_rst low exactly RST_CYCLES=2 cycles after last accept.
REQ-040 Run where core_insn=32'h00000073 valid at run cycle 10 -> done=1, halted=1, timeout=0, cycle_cnt=10.
REQ-041 Run with no halt, MAX_CYCLES=75 -> FIN after 75 run cycles, timeout=1, cycle_cnt=74, core_rst=1.
REQ-042 ADDR_W=2, 5 words without ld_last -> 4 writes (addr 0..3), overflow=1, 5th word not accepted (ld_ready=0).
REQ-043 Halt on cycle 74 of 75 -> halted=1, timeout=0.
REQ-044 rst low during LOAD at addr 2, then start again -> reload begins at addr 0, all flags 0.
